// File: rtl/mtimer_if.sv
// Request/response bus between a core-side master and the machine timer.
// One request per cycle, response exactly one cycle later, no back-pressure.
interface mtimer_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_write;
    logic [4:0]      req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mtimer.sv
// RISC-V style machine timer: 64-bit mtime with prescaler, mtimecmp compare,
// hi-shadow for coherent 64-bit reads, and a registered MTI pending level.
module mtimer #(
    parameter int XLEN       = 32,
    parameter int PRESCALE_W = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    mtimer_if.slave  bus,
    output logic     mti_pending
);
    localparam logic [2:0] IDX_MTIME_LO = 3'd0;
    localparam logic [2:0] IDX_MTIME_HI = 3'd1;
    localparam logic [2:0] IDX_CMP_LO   = 3'd2;
    localparam logic [2:0] IDX_CMP_HI   = 3'd3;
    localparam logic [2:0] IDX_CTRL     = 3'd4;

    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;
    logic [XLEN-1:0]       shadow_q, shadow_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PRESCALE_W-1:0] div_q, div_d;
    logic                  en_q, en_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]       resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic                  mti_q, mti_d;

    logic [2:0]      idx;
    logic            mapped;
    logic            rd_en;
    logic            wr_en;
    logic            tick;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] ctrl_rd;
    logic            unused_addr_bits;

    assign idx              = bus.req_addr[4:2];
    assign unused_addr_bits = ^bus.req_addr[1:0];
    assign mapped           = (idx <= IDX_CTRL);
    assign rd_en            = bus.req_valid && !bus.req_write;
    assign wr_en            = bus.req_valid && bus.req_write && mapped;
    assign tick             = en_q && (presc_q == div_q);

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[PRESCALE_W:0] = {div_q, en_q};
        case (idx)
            IDX_MTIME_LO: rd_val = mtime_q[31:0];
            IDX_MTIME_HI: rd_val = shadow_q;
            IDX_CMP_LO:   rd_val = mtimecmp_q[31:0];
            IDX_CMP_HI:   rd_val = mtimecmp_q[63:32];
            IDX_CTRL:     rd_val = ctrl_rd;
            default:      rd_val = '0;
        endcase
    end

    always_comb begin
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        presc_d    = en_q ? (tick ? '0 : presc_q + 1'b1) : presc_q;
        mtimecmp_d = mtimecmp_q;
        shadow_d   = shadow_q;
        en_d       = en_q;
        div_d      = div_q;

        if (rd_en && idx == IDX_MTIME_LO) begin
            shadow_d = mtime_q[63:32];
        end

        // A write to either mtime half overrides the increment; the other half keeps its old value.
        if (wr_en) begin
            case (idx)
                IDX_MTIME_LO: begin
                    mtime_d = {mtime_q[63:32], bus.req_wdata};
                    presc_d = '0;
                end
                IDX_MTIME_HI: begin
                    mtime_d = {bus.req_wdata, mtime_q[31:0]};
                    presc_d = '0;
                end
                IDX_CMP_LO: mtimecmp_d = {mtimecmp_q[63:32], bus.req_wdata};
                IDX_CMP_HI: mtimecmp_d = {bus.req_wdata, mtimecmp_q[31:0]};
                IDX_CTRL: begin
                    en_d    = bus.req_wdata[0];
                    div_d   = bus.req_wdata[PRESCALE_W:1];
                    presc_d = '0;
                end
                default: ;
            endcase
        end

        resp_valid_d = bus.req_valid;
        resp_err_d   = bus.req_valid && !mapped;
        resp_rdata_d = (rd_en && mapped) ? rd_val : '0;
        mti_d        = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q      <= '0;
            mtimecmp_q   <= '1;
            shadow_q     <= '0;
            presc_q      <= '0;
            div_q        <= '0;
            en_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mti_q        <= 1'b0;
        end else begin
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            shadow_q     <= shadow_d;
            presc_q      <= presc_d;
            div_q        <= div_d;
            en_q         <= en_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mti_q        <= mti_d;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign mti_pending    = mti_q;
endmodule

// File: doc/mtimer.md
MTIMER -- requirements
Module: mtimer

Interface
REQ-001 Parameter XLEN, default 32, bus data width; only 32 is supported.
REQ-002 Parameter PRESCALE_W, default 16, width of the prescaler divisor field.
REQ-003 The clock port SHALL be clk, input, 1 bit, with all state updated on its rising edge.
REQ-004 The reset port SHALL be rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 Port req_valid SHALL be an input, 1 bit: a bus request is present this cycle.
REQ-006 Port req_write SHALL be an input, 1 bit: 1 = write, 0 = read.
REQ-007 Port req_addr SHALL be an input, 5 bits: byte offset of the register; bits [1:0] are ignored.
REQ-008 Port req_wdata SHALL be an input, XLEN bits: write data.
REQ-009 Port resp_valid SHALL be an output, 1 bit: the response for the previous cycle's request.
REQ-010 Port resp_rdata SHALL be an output, XLEN bits: read data, valid when resp_valid=1.
REQ-011 Port resp_err SHALL be an output, 1 bit: the previous request targeted an unmapped offset.
REQ-012 Port mti_pending SHALL be an output, 1 bit: the machine-timer interrupt pending level, consumed by the CSR file mip.MTI input.

Function
REQ-013 The register map SHALL be:
- 0x00 MTIME_LO
- 0x04 MTIME_HI
- 0x08 MTIMECMP_LO
- 0x0C MTIMECMP_HI
- 0x10 CTRL: bit0 EN; bits[16:1] DIV (PRESCALE_W bits); all other bits read 0.
REQ-014 Offsets 0x14–0x1C SHALL be unmapped.
- Reads return 0 with resp_err=1.
- Writes are dropped with resp_err=1.
REQ-015 The block SHALL accept a request on every cycle with no back-pressure.
- resp_valid is asserted exactly 1 cycle after each cycle in which req_valid=1.
- resp_valid is deasserted otherwise.
REQ-016 Reads SHALL return register values as they were before any same-cycle write or increment.
REQ-017 Reading MTIME_LO SHALL latch mtime[63:32] into a hi-shadow register in the same cycle.
REQ-018 Reading MTIME_HI SHALL return the hi-shadow, not the live mtime[63:32].
REQ-019 The prescaler SHALL be a PRESCALE_W-bit counter that increments each cycle while EN=1.
- When it equals DIV, it resets to 0 and mtime increments by 1.
- DIV=0 therefore increments mtime every cycle.
REQ-020 The prescaler SHALL hold its value while EN=0, and mtime SHALL NOT increment.
REQ-021 mtime SHALL wrap from 0xFFFF_FFFF_FFFF_FFFF to 0 with no flag.
REQ-022 A write to either mtime half SHALL take priority over a same-cycle increment.
- The written half takes wdata.
- The other half keeps its pre-cycle value, with no carry applied.
- The prescaler is cleared to 0.
REQ-023 A write to CTRL SHALL clear the prescaler to 0.
REQ-024 Writes to MTIMECMP_LO or MTIMECMP_HI SHALL replace only that 32-bit half.
REQ-025 mti_pending SHALL be registered and equal to (mtime >= mtimecmp) evaluated on the previous cycle's register values.
- The comparison is a 64-bit unsigned compare.
- Latency from any mtime or mtimecmp change to mti_pending is 1 cycle.
REQ-026 mti_pending SHALL be a level signal, cleared only by the compare becoming false; it has no acknowledge.

Reset
REQ-027 While rst_n=0, the following SHALL hold immediately, independent of clk:
- mtime = 0, mtimecmp = 0xFFFF_FFFF_FFFF_FFFF, hi-shadow = 0, prescaler = 0.
- CTRL: EN=0, DIV=0.
- Outputs: resp_valid = 0, resp_rdata = 0, resp_err = 0, mti_pending = 0.
REQ-028 A request present in the cycle reset asserts SHALL be discarded and SHALL produce no response after reset release.
REQ-029 Operation SHALL resume on the first rising clk edge after rst_n deasserts.

Verification
REQ-030 Reset release, then read CTRL:
- resp_valid=1 one cycle later, rdata=0, err=0.
- mti_pending stays 0 for 100 cycles.
REQ-031 Write CTRL=0x1 (EN=1, DIV=0), wait 10 cycles, read MTIME_LO -> rdata=10±1.
REQ-032 Set CTRL EN=1, DIV=3:
- mtime increments once every 4 cycles.
- Writing MTIME_LO=0xFFFF_FFFF, MTIME_HI=0 then running 4 cycles reads MTIME_LO=0 and MTIME_HI=1 (the carry propagates).
REQ-033 Timer interrupt assert and clear:
- Set MTIMECMP_HI=0, MTIMECMP_LO=20 with EN=1, DIV=0.
- mti_pending rises exactly 1 cycle after mtime reaches 20.
- Writing MTIMECMP_LO=0xFFFF_FFFF, MTIMECMP_HI=0xFFFF_FFFF drops mti_pending 1 cycle later.
REQ-034 Shadow coherence:
- Set mtime=0x0000_0000_FFFF_FFFE with EN=1, DIV=0, then read MTIME_LO.
- A later MTIME_HI read returns 0 even though mtime has since carried into the high half.
REQ-035 Error path and async reset:
- Read of 0x18 -> resp_err=1, rdata=0.
- Asserting rst_n=0 mid-count clears mtime and mti_pending within the same cycle, without a clk edge.
